// File: rtl/matrix_accel_soc.sv
// rtl/matrix_accel_soc.sv - matrix accelerator demo SoC: preloadable RAM, vector-add sequencer, control regs, UART TX

module soc_dram #(
    parameter int DEPTH     = 8192,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_we,
    input  logic [IDX_WIDTH-1:0] init_idx,
    input  logic [63:0]          init_wdata,
    input  logic                 we,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic [63:0]          wdata,
    output logic [63:0]          rdata
);
    logic [63:0] init_val [0:DEPTH-1];
    logic [63:0] mem      [0:DEPTH-1];

    // Preload image; normally filled from outside through the hierarchy.
    always @(posedge clk) begin
        if (init_we) init_val[init_idx] <= init_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= init_val;
        end else if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end
endmodule

module soc_ram #(
    parameter int                 AW        = 32,
    parameter logic [AW-1:0]      BASE      = 32'h8000_0000,
    parameter int                 DEPTH     = 8192,
    parameter int                 IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [AW-1:0] offset;
    logic          unused_addr_bits;

    assign offset           = addr - BASE;
    assign unused_addr_bits = ^{offset[AW-1:IDX_WIDTH+3], offset[2:0]};

    soc_dram #(.DEPTH(DEPTH), .IDX_WIDTH(IDX_WIDTH)) i_dram (
        .clk        (clk),
        .rst        (rst),
        .init_we    (1'b0),
        .init_idx   ('0),
        .init_wdata ('0),
        .we         (we),
        .idx        (offset[IDX_WIDTH+2:3]),
        .wdata      (wdata),
        .rdata      (rdata)
    );
endmodule

module soc_ctrl_regs #(
    parameter int NUM_REGS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(NUM_REGS)-1:0]  waddr,
    input  logic [31:0]                  wdata,
    input  logic                         dec_inc,
    input  logic                         halt_set,
    input  logic                         illegal_set,
    input  logic                         rx_sync,
    output logic [NUM_REGS-1:0][31:0]    reg_q_o
);
    // Later assignments win: halt/illegal flags and the rx mirror override a WREG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q_o <= '0;
        end else begin
            if (dec_inc) reg_q_o[2] <= reg_q_o[2] + 32'd1;
            if (we) reg_q_o[waddr] <= wdata;
            if (halt_set) reg_q_o[0] <= 32'h0000_00FF;
            if (illegal_set) reg_q_o[1][31] <= 1'b1;
            reg_q_o[1][0] <= rx_sync;
        end
    end
endmodule

module soc_uart_tx #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                tx      <= 1'b0;
                shreg   <= {1'b1, data};
                div_cnt <= '0;
                bit_cnt <= '0;
            end
        end else if (div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
            // bit_cnt == 9 means the stop bit has just completed its full period
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

module soc_seq #(
    parameter int            AW   = 32,
    parameter logic [AW-1:0] BASE = 32'h8000_0000,
    parameter int            IW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    input  logic [63:0]   mem_rdata,
    output logic          reg_we,
    output logic [1:0]    reg_waddr,
    output logic [31:0]   reg_wdata,
    output logic          dec_inc,
    output logic          halt_set,
    output logic          illegal_set,
    output logic          uart_start,
    output logic [7:0]    uart_data,
    input  logic          uart_busy
);
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_RD_A      = 3'd2;
    localparam logic [2:0] ST_RD_B      = 3'd3;
    localparam logic [2:0] ST_WR        = 3'd4;
    localparam logic [2:0] ST_UART_WAIT = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_PUTC = 8'h01;
    localparam logic [7:0] OP_WREG = 8'h02;
    localparam logic [7:0] OP_VADD = 8'h03;
    localparam logic [7:0] OP_HALT = 8'hFF;

    logic [2:0]    state;
    logic [IW-1:0] pc;
    logic [38:0]   instr_q;
    logic [63:0]   a_q;
    logic [IW-1:0] word_idx;
    logic [7:0]    op;
    logic          is_decode;
    logic          op_legal;
    logic          wreg_halt;
    logic [63:0]   vadd_sum;

    assign op        = mem_rdata[63:56];
    assign is_decode = (state == ST_DECODE);
    assign op_legal  = (op == OP_NOP) || (op == OP_PUTC) || (op == OP_WREG) ||
                       (op == OP_VADD) || (op == OP_HALT);

    always_comb begin
        word_idx = pc;
        case (state)
            ST_RD_A: word_idx = instr_q[25:13];
            ST_RD_B: word_idx = instr_q[38:26];
            ST_WR:   word_idx = instr_q[12:0];
            default: word_idx = pc;
        endcase
    end

    // Lanes are summed independently so carries never cross a 16-bit boundary.
    always_comb begin
        vadd_sum = '0;
        for (int l = 0; l < 4; l++) begin
            vadd_sum[16*l +: 16] = a_q[16*l +: 16] + mem_rdata[16*l +: 16];
        end
    end

    assign mem_addr    = BASE + AW'({word_idx, 3'b000});
    assign mem_we      = (state == ST_WR);
    assign mem_wdata   = vadd_sum;
    assign reg_we      = is_decode && (op == OP_WREG);
    assign reg_waddr   = mem_rdata[49:48];
    assign reg_wdata   = mem_rdata[31:0];
    assign wreg_halt   = (mem_rdata[49:48] == 2'd0) && (mem_rdata[31:0] == 32'h0000_00FF);
    assign dec_inc     = is_decode;
    assign halt_set    = is_decode && ((op == OP_HALT) || !op_legal);
    assign illegal_set = is_decode && !op_legal;
    assign uart_start  = (state == ST_UART_WAIT) && !uart_busy;
    assign uart_data   = instr_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= '0;
            instr_q <= '0;
            a_q     <= '0;
        end else begin
            case (state)
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    instr_q <= mem_rdata[38:0];
                    case (op)
                        OP_NOP: begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end
                        OP_PUTC: state <= ST_UART_WAIT;
                        OP_WREG: begin
                            pc    <= pc + 1'b1;
                            state <= wreg_halt ? ST_HALT : ST_FETCH;
                        end
                        OP_VADD: state <= ST_RD_A;
                        default: state <= ST_HALT;
                    endcase
                end
                ST_RD_A: state <= ST_RD_B;
                ST_RD_B: begin
                    a_q   <= mem_rdata;
                    state <= ST_WR;
                end
                ST_WR: begin
                    pc    <= pc + 1'b1;
                    state <= ST_FETCH;
                end
                ST_UART_WAIT: begin
                    if (!uart_busy) begin
                        pc    <= pc + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end
endmodule

module matrix_accel_soc #(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] RAM_BASE       = 32'h8000_0000,
    parameter logic [31:0]               RAM_LENGTH     = 32'h0001_0000,
    parameter int                        NUM_CTRL_REGS  = 4,
    parameter int                        UART_DIV       = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tx,
    input  logic rx
);
    localparam int RAM_WORDS = int'(RAM_LENGTH) / (AXI_DATA_WIDTH / 8);
    localparam int IW        = $clog2(RAM_WORDS);

    logic                                 rx_meta;
    logic                                 rx_sync;
    logic                                 mem_we;
    logic [AXI_ADDR_WIDTH-1:0]            mem_addr;
    logic [63:0]                          mem_wdata;
    logic [63:0]                          mem_rdata;
    logic                                 reg_we;
    logic [1:0]                           reg_waddr;
    logic [31:0]                          reg_wdata;
    logic                                 dec_inc;
    logic                                 halt_set;
    logic                                 illegal_set;
    logic                                 uart_start;
    logic [7:0]                           uart_data;
    logic                                 uart_busy;
    logic [NUM_CTRL_REGS-1:0][31:0]       ctrl_regs_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    soc_ram #(.AW(AXI_ADDR_WIDTH), .BASE(RAM_BASE), .DEPTH(RAM_WORDS), .IDX_WIDTH(IW)) i_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    soc_seq #(.AW(AXI_ADDR_WIDTH), .BASE(RAM_BASE), .IW(IW)) i_seq (
        .clk         (clk),
        .rst         (rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .dec_inc     (dec_inc),
        .halt_set    (halt_set),
        .illegal_set (illegal_set),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy)
    );

    soc_ctrl_regs #(.NUM_REGS(NUM_CTRL_REGS)) i_ctrl_regs (
        .clk         (clk),
        .rst         (rst),
        .we          (reg_we),
        .waddr       (reg_waddr),
        .wdata       (reg_wdata),
        .dec_inc     (dec_inc),
        .halt_set    (halt_set),
        .illegal_set (illegal_set),
        .rx_sync     (rx_sync),
        .reg_q_o     (ctrl_regs_unused)
    );

    soc_uart_tx #(.DIV(UART_DIV)) i_uart (
        .clk   (clk),
        .rst   (rst),
        .start (uart_start),
        .data  (uart_data),
        .busy  (uart_busy),
        .tx    (tx)
    );
endmodule

// File: tb/tb_matrix_accel_soc.sv
// tb/tb_matrix_accel_soc.sv - self-checking bench for matrix_accel_soc
module tb_matrix_accel_soc;
    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic rx;

    always #5 clk = ~clk;

    matrix_accel_soc dut (
        .clk (clk),
        .rst (rst),
        .tx  (tx),
        .rx  (rx)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] p0, p1, p2, p3;
        logic [63:0] d8, d9;
        int          chk_addr;
        logic [63:0] chk_val;
        logic [31:0] r0, r1, r2, r3;
        int          cyc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] i_nop();
        return 64'h0;
    endfunction
    function automatic logic [63:0] i_halt();
        return 64'hFF00_0000_0000_0000;
    endfunction
    function automatic logic [63:0] i_putc(input logic [7:0] b);
        return {8'h01, 48'h0, b};
    endfunction
    function automatic logic [63:0] i_wreg(input int r, input logic [31:0] v);
        logic [63:0] w;
        w = '0;
        w[63:56] = 8'h02;
        w[49:48] = 2'(r);
        w[31:0]  = v;
        return w;
    endfunction
    function automatic logic [63:0] i_vadd(input int d, input int a, input int b);
        logic [63:0] w;
        w = '0;
        w[63:56] = 8'h03;
        w[38:26] = 13'(b);
        w[25:13] = 13'(a);
        w[12:0]  = 13'(d);
        return w;
    endfunction

    function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            int s;
            s = int'(a[16*l +: 16]) + int'(b[16*l +: 16]);
            r[16*l +: 16] = 16'(s % 65536);
        end
        return r;
    endfunction

    function automatic logic [31:0] regv(input int k);
        return dut.i_ctrl_regs.reg_q_o[k];
    endfunction

    function automatic logic [63:0] memv(input int a);
        return dut.i_ram.i_dram.mem[a];
    endfunction

    task automatic ld(input int a, input logic [63:0] w);
        dut.i_ram.i_dram.init_val[a] = w;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8192; i++) dut.i_ram.i_dram.init_val[i] = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns cycles from reset release to reg0 == 0xFF, or -1 on timeout.
    task automatic run_prog(output int cyc, output bit tx_idle);
        cyc = 0;
        tx_idle = 1'b1;
        do_reset();
        while (regv(0) != 32'hFF && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (tx !== 1'b1) tx_idle = 1'b0;
        end
        if (regv(0) != 32'hFF) cyc = -1;
    endtask

    task automatic uart_expect(input logic [7:0] b, input string nm);
        logic [9:0] fr;
        int t;
        fr = {1'b1, b, 1'b0};
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s_start actual=no_start_bit required=start_bit", nm);
        end else begin
            repeat (8) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                check($sformatf("%s_bit%0d", nm, i), 64'(tx), 64'(fr[i]));
                if (i < 9) repeat (16) @(negedge clk);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    vec_t vecs[8];
    int   cyc;
    bit   tx_idle;

    initial begin
        vecs[0] = '{i_halt(), 0, 0, 0, 0, 0, 10, 64'h0, 32'hFF, 32'h1, 32'd1, 32'h0, 2};
        vecs[1] = '{i_vadd(10, 8, 9), i_halt(), 0, 0, 64'h0001_0002_FFFF_0004, 64'h0001_0003_0002_0005,
                    10, 64'h0002_0005_0001_0009, 32'hFF, 32'h1, 32'd2, 32'h0, 7};
        vecs[2] = '{i_wreg(3, 32'h1234_5678), i_wreg(0, 32'hFF), i_nop(), i_halt(), 0, 0,
                    10, 64'h0, 32'hFF, 32'h1, 32'd2, 32'h1234_5678, 4};
        vecs[3] = '{64'h7E00_0000_0000_0000, 0, 0, 0, 0, 0, 10, 64'h0, 32'hFF, 32'h8000_0001, 32'd1, 32'h0, 2};
        vecs[4] = '{i_nop(), i_nop(), i_wreg(3, 32'hDEAD_BEEF), i_halt(), 0, 0,
                    10, 64'h0, 32'hFF, 32'h1, 32'd4, 32'hDEAD_BEEF, 8};
        vecs[5] = '{i_vadd(8, 8, 8), i_halt(), 0, 0, 64'h8000_FFFF_0001_7FFF, 64'h1,
                    8, 64'h0000_FFFE_0002_FFFE, 32'hFF, 32'h1, 32'd2, 32'h0, 7};
        vecs[6] = '{i_wreg(0, 32'h1FF), i_halt(), 0, 0, 0, 0, 10, 64'h0, 32'hFF, 32'h1, 32'd2, 32'h0, 4};
        vecs[7] = '{i_vadd(10, 8, 9), i_vadd(11, 10, 10), i_halt(), 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0001_0001_0001_0001, 11, 64'h0, 32'hFF, 32'h1, 32'd3, 32'h0, 12};

        rst = 1'b1;
        rx  = 1'b1;
        clear_prog();
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(tx), 64'h1);
        for (int k = 0; k < 4; k++) check($sformatf("reset_reg%0d", k), 64'(regv(k)), 64'h0);

        for (int v = 0; v < 8; v++) begin
            clear_prog();
            ld(0, vecs[v].p0); ld(1, vecs[v].p1); ld(2, vecs[v].p2); ld(3, vecs[v].p3);
            ld(8, vecs[v].d8); ld(9, vecs[v].d9);
            run_prog(cyc, tx_idle);
            check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].cyc));
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_reg0", v), 64'(regv(0)), 64'(vecs[v].r0));
            check($sformatf("v%0d_reg1", v), 64'(regv(1)), 64'(vecs[v].r1));
            check($sformatf("v%0d_reg2", v), 64'(regv(2)), 64'(vecs[v].r2));
            check($sformatf("v%0d_reg3", v), 64'(regv(3)), 64'(vecs[v].r3));
            check($sformatf("v%0d_mem%0d", v, vecs[v].chk_addr), memv(vecs[v].chk_addr), vecs[v].chk_val);
            check($sformatf("v%0d_tx_idle", v), 64'(tx_idle), 64'h1);
        end

        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("rx_mirror_low", 64'(regv(1) & 32'h1), 64'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rx_mirror_high", 64'(regv(1) & 32'h1), 64'h1);

        // Randomised programs of NOP/WREG/VADD over an 8-word data region at 16..23
        for (int it = 0; it < 8; it++) begin
            logic [63:0] mdl [8];
            logic [31:0] exp_r3;
            int n, exp_cyc;
            clear_prog();
            for (int i = 0; i < 8; i++) begin
                mdl[i] = {$urandom, $urandom};
                ld(16 + i, mdl[i]);
            end
            n = $urandom_range(2, 6);
            exp_cyc = 0;
            exp_r3 = 32'h0;
            for (int k = 0; k < n; k++) begin
                int sel;
                sel = $urandom_range(0, 2);
                if (sel == 0) begin
                    ld(k, i_nop());
                    exp_cyc += 2;
                end else if (sel == 1) begin
                    exp_r3 = $urandom;
                    ld(k, i_wreg(3, exp_r3));
                    exp_cyc += 2;
                end else begin
                    int d, a, b;
                    d = $urandom_range(0, 7); a = $urandom_range(0, 7); b = $urandom_range(0, 7);
                    ld(k, i_vadd(16 + d, 16 + a, 16 + b));
                    mdl[d] = lane_add(mdl[a], mdl[b]);
                    exp_cyc += 5;
                end
            end
            ld(n, i_halt());
            exp_cyc += 2;
            run_prog(cyc, tx_idle);
            check($sformatf("rnd%0d_cycles", it), 64'(cyc), 64'(exp_cyc));
            check($sformatf("rnd%0d_reg2", it), 64'(regv(2)), 64'(n + 1));
            check($sformatf("rnd%0d_reg3", it), 64'(regv(3)), 64'(exp_r3));
            for (int i = 0; i < 8; i++) check($sformatf("rnd%0d_mem%0d", it, 16 + i), memv(16 + i), mdl[i]);
        end

        clear_prog();
        ld(0, i_putc(8'h41));
        ld(1, i_halt());
        do_reset();
        uart_expect(8'h41, "putc41");
        check("putc41_reg0", 64'(regv(0)), 64'hFF);
        check("putc41_reg2", 64'(regv(2)), 64'd2);

        clear_prog();
        ld(0, i_putc(8'hA5));
        ld(1, i_putc(8'h3C));
        ld(2, i_halt());
        do_reset();
        uart_expect(8'hA5, "b2b_a5");
        uart_expect(8'h3C, "b2b_3c");
        check("b2b_reg2", 64'(regv(2)), 64'd3);

        clear_prog();
        ld(0, i_putc(8'h55));
        ld(1, i_halt());
        do_reset();
        cyc = 0;
        while (tx !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (40) @(negedge clk);
        check("midreset_tx_before", 64'(tx), 64'h0);
        #1 rst = 1'b1;
        #1;
        check("midreset_tx_now", 64'(tx), 64'h1);
        check("midreset_reg0", 64'(regv(0)), 64'h0);
        check("midreset_reg2", 64'(regv(2)), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        uart_expect(8'h55, "rerun55");
        check("rerun_reg0", 64'(regv(0)), 64'hFF);
        check("rerun_reg2", 64'(regv(2)), 64'd2);

        // PC wrap: word 8191 rewrites word 0 so the wrapped fetch is observable
        clear_prog();
        ld(0, i_wreg(3, 32'd5));
        ld(1, 64'd5);
        ld(8191, i_vadd(0, 0, 1));
        do_reset();
        cyc = 0;
        while (regv(3) != 32'd10 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("wrap_cycles", 64'(cyc), 64'd16389);
        check("wrap_reg2", 64'(regv(2)), 64'd8193);
        check("wrap_mem0", memv(0), i_wreg(3, 32'd10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
